// File: rtl/fir_decimator_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_decimator_mc_if
// Purpose  : Sample, output and coefficient-load bus of fir_decimator_mc.
// Revision : 1.0
// ============================================================================
interface fir_decimator_mc_if #(
  parameter int ORD         = 255,
  parameter int CH          = 2,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16
);
  localparam int c_chw = (CH > 1) ? $clog2(CH) : 1;
  localparam int c_aw  = $clog2(ORD + 1);

  logic                          din_valid;
  logic                          din_ready;
  logic signed [SAMPLE_SIZE-1:0] din;
  logic [c_chw-1:0]              din_ch;
  logic                          dout_valid;
  logic signed [SAMPLE_SIZE-1:0] dout;
  logic [c_chw-1:0]              dout_ch;
  logic                          c_we;
  logic [c_aw-1:0]               c_addr;
  logic signed [COEFF_SIZE-1:0]  c_in;

  modport master (
    output din_valid, din, din_ch, c_we, c_addr, c_in,
    input  din_ready, dout_valid, dout, dout_ch
  );

  modport slave (
    input  din_valid, din, din_ch, c_we, c_addr, c_in,
    output din_ready, dout_valid, dout, dout_ch
  );
endinterface
`default_nettype wire

// File: rtl/fir_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module   : fir_decimator_mc
// Purpose  : Time-multiplexed multi-channel FIR low-pass decimator, one MAC.
// Revision : 1.0
// ============================================================================
module fir_decimator_mc #(
  parameter int ORD         = 255,
  parameter int D           = 8,
  parameter int CH          = 2,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16,
  parameter int ACC_SIZE    = 40,
  parameter int OUT_SHIFT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  fir_decimator_mc_if.slave  bus
);
  localparam int c_taps = ORD + 1;
  localparam int c_aw   = $clog2(c_taps);
  localparam int c_cw   = $clog2(c_taps + 1);
  localparam int c_chw  = (CH > 1) ? $clog2(CH) : 1;
  localparam int c_phw  = $clog2(D);
  localparam int c_pw   = COEFF_SIZE + SAMPLE_SIZE;
  localparam logic signed [ACC_SIZE-1:0] c_half = {{(ACC_SIZE-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACC_SIZE-1:0] c_ymax = {{(ACC_SIZE-SAMPLE_SIZE+1){1'b0}}, {(SAMPLE_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] c_ymin = {{(ACC_SIZE-SAMPLE_SIZE+1){1'b1}}, {(SAMPLE_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic signed [SAMPLE_SIZE-1:0] r_buf  [CH][c_taps];
  logic signed [COEFF_SIZE-1:0]  r_coef [c_taps];
  logic [c_aw-1:0]               r_wptr [CH];
  logic [c_phw-1:0]              r_phase[CH];

  logic [c_cw-1:0]               r_k;
  logic [c_aw-1:0]               r_rd;
  logic [c_chw-1:0]              r_mch;
  logic signed [c_pw-1:0]        r_prod;
  logic signed [ACC_SIZE-1:0]    r_acc;
  logic                          r_dout_valid;
  logic signed [SAMPLE_SIZE-1:0] r_dout;
  logic [c_chw-1:0]              r_dout_ch;

  logic                          w_ready, w_ch_ok, w_take, w_wrap, w_coef_we, w_k_live;
  logic [c_aw-1:0]               w_kidx;
  logic signed [c_pw-1:0]        w_prod;
  logic signed [ACC_SIZE-1:0]    w_rnd, w_sh;
  logic signed [SAMPLE_SIZE-1:0] w_y;

  assign w_ready   = (r_state == S_IDLE) && !rst;
  assign w_ch_ok   = int'(bus.din_ch) < CH;
  assign w_take    = bus.din_valid && w_ready && w_ch_ok;
  assign w_wrap    = w_take && (r_phase[bus.din_ch] == c_phw'(D - 1));
  assign w_coef_we = bus.c_we && ((r_state == S_INIT) || (r_state == S_IDLE))
                     && (int'(bus.c_addr) < c_taps);

  // MAC runs one extra step (k == ORD+1) to drain the product register.
  assign w_k_live = r_k < c_cw'(c_taps);
  assign w_kidx   = w_k_live ? r_k[c_aw-1:0] : '0;
  assign w_prod   = w_k_live ? (c_pw'(r_coef[w_kidx]) * c_pw'(r_buf[r_mch][r_rd])) : '0;

  assign w_rnd = r_acc + c_half;
  assign w_sh  = w_rnd >>> OUT_SHIFT;

  always_comb begin
    w_y = w_sh[SAMPLE_SIZE-1:0];
    if (w_sh > c_ymax) begin
      w_y = c_ymax[SAMPLE_SIZE-1:0];
    end else if (w_sh < c_ymin) begin
      w_y = c_ymin[SAMPLE_SIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (r_k == c_cw'(ORD)) w_next = S_IDLE;
      S_IDLE:  if (w_wrap) w_next = S_MAC;
      S_MAC:   if (r_k == c_cw'(c_taps)) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k          <= '0;
      r_rd         <= '0;
      r_mch        <= '0;
      r_prod       <= '0;
      r_acc        <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      for (int i = 0; i < CH; i++) begin
        r_wptr[i]  <= '0;
        r_phase[i] <= '0;
      end
    end else begin
      r_dout_valid <= 1'b0;
      case (r_state)
        S_INIT: r_k <= r_k + 1'b1;
        S_IDLE: begin
          if (w_take) begin
            r_wptr[bus.din_ch]  <= (r_wptr[bus.din_ch] == c_aw'(ORD)) ? '0 : r_wptr[bus.din_ch] + 1'b1;
            r_phase[bus.din_ch] <= (r_phase[bus.din_ch] == c_phw'(D - 1)) ? '0 : r_phase[bus.din_ch] + 1'b1;
          end
          if (w_wrap) begin
            r_mch  <= bus.din_ch;
            r_rd   <= r_wptr[bus.din_ch];
            r_k    <= '0;
            r_acc  <= '0;
            r_prod <= '0;
          end
        end
        S_MAC: begin
          r_prod <= w_prod;
          r_acc  <= r_acc + ACC_SIZE'(r_prod);
          r_k    <= r_k + 1'b1;
          r_rd   <= (r_rd == '0) ? c_aw'(ORD) : r_rd - 1'b1;
        end
        S_OUT: begin
          r_dout_valid <= 1'b1;
          r_dout       <= w_y;
          r_dout_ch    <= r_mch;
        end
        default: r_k <= '0;
      endcase
    end
  end

  // Sample storage: INIT clears one address of every channel per cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      for (int i = 0; i < CH; i++) begin
        r_buf[i][r_k[c_aw-1:0]] <= '0;
      end
    end else if (w_take) begin
      r_buf[bus.din_ch][r_wptr[bus.din_ch]] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (w_coef_we) begin
      r_coef[bus.c_addr] <= bus.c_in;
    end
  end

  assign bus.din_ready  = w_ready;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
endmodule
`default_nettype wire

// File: tb/tb_fir_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_decimator_mc
// Purpose  : Self-checking bench for fir_decimator_mc against a convolution model.
// Revision : 1.0
// ============================================================================
module tb_fir_decimator_mc;
  localparam int ORD  = 255;
  localparam int D    = 8;
  localparam int CH   = 2;
  localparam int ACC  = 40;
  localparam int OSH  = 15;
  localparam int TAPS = ORD + 1;
  localparam int LAT  = ORD + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_decimator_mc_if #(.ORD(ORD), .CH(CH), .COEFF_SIZE(16), .SAMPLE_SIZE(16)) bus ();

  fir_decimator_mc #(
    .ORD(ORD), .D(D), .CH(CH), .COEFF_SIZE(16), .SAMPLE_SIZE(16),
    .ACC_SIZE(ACC), .OUT_SHIFT(OSH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit tmo_any  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: coefficient table plus full per-channel sample history.
  int m_coef [TAPS];
  int hist   [CH][1024];
  int hcnt   [CH];
  int exp_y  [$];
  int exp_ch [$];

  function automatic int model_y(int ch);
    logic signed [ACC-1:0] acc, rnd, sh;
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      int idx = hcnt[ch] - 1 - k;
      if (idx >= 0) acc = acc + ACC'(longint'(m_coef[k]) * longint'(hist[ch][idx]));
    end
    rnd = acc + (40'sd1 <<< (OSH - 1));
    sh  = rnd >>> OSH;
    if (sh > 32767) return 32767;
    if (sh < -32768) return -32768;
    return int'(sh);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CH; c++) hcnt[c] = 0;
    exp_y.delete();
    exp_ch.delete();
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 400 && !bus.din_ready; g++) begin
      @(posedge clk); #1;
    end
    model_clear();
  endtask

  task automatic load_coef(input int k, input int v);
    for (int g = 0; g < 1000 && !bus.din_ready; g++) begin
      @(posedge clk); #1;
    end
    bus.c_we = 1'b1; bus.c_addr = 8'(k); bus.c_in = 16'(v);
    @(posedge clk);
    m_coef[k] = v;
    #1 bus.c_we = 1'b0;
  endtask

  task automatic drive_sample(input int ch, input int val, input bit we, input int wa, input int wv,
                              output bit wrapped);
    wrapped = 1'b0;
    bus.din_valid = 1'b1; bus.din = 16'(val); bus.din_ch = 1'(ch);
    for (int g = 0; g < 1000 && !bus.din_ready; g++) begin
      @(posedge clk); #1;
    end
    if (!bus.din_ready) begin
      tmo_any = 1'b1;
      bus.din_valid = 1'b0;
      return;
    end
    bus.c_we = we; bus.c_addr = 8'(wa); bus.c_in = 16'(wv);
    @(posedge clk);
    if (we) m_coef[wa] = wv;
    hist[ch][hcnt[ch]] = val;
    hcnt[ch]++;
    if (hcnt[ch] % D == 0) begin
      wrapped = 1'b1;
      exp_y.push_back(model_y(ch));
      exp_ch.push_back(ch);
    end
    #1 bus.din_valid = 1'b0; bus.c_we = 1'b0;
  endtask

  // Waits for dout_valid after a wrapping accept; optionally pokes c[0] and
  // presents a junk sample while the block is busy.
  task automatic wait_out(input bit busy_wr, input bit junk, output int lat, output int y,
                          output int ch, output bit early_rdy, output bit rdy_out);
    lat = -1; y = 0; ch = -1; early_rdy = 1'b0; rdy_out = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      bus.c_we = busy_wr && (i <= 20);
      bus.c_addr = '0; bus.c_in = '0;
      bus.din_valid = junk; bus.din = 16'sh7777; bus.din_ch = '0;
      @(posedge clk); #1;
      if (bus.dout_valid) begin
        lat = i; y = int'(bus.dout); ch = int'(bus.dout_ch); rdy_out = bus.din_ready;
        break;
      end
      if (bus.din_ready) early_rdy = 1'b1;
    end
    bus.c_we = 1'b0; bus.din_valid = 1'b0;
  endtask

  task automatic test_reset();
    int low_cnt;
    bit bad_out;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.din_ready !== 1'b0) $display("FAIL reset_ready_in_rst: got %b expected 0", bus.din_ready);
    else n_pass++;
    rst = 1'b0;
    low_cnt = 0; bad_out = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      bus.c_we = 1'b1; bus.c_addr = 8'(i); bus.c_in = 16'(16 * i);
      m_coef[i] = 16 * i;
      if (!bus.din_ready) low_cnt++;
      if (bus.dout_valid || bus.dout != 0) bad_out = 1'b1;
      @(posedge clk); #1;
    end
    bus.c_we = 1'b0;
    for (int g = 0; g < 20 && !bus.din_ready; g++) begin
      low_cnt++;
      @(posedge clk); #1;
    end
    model_clear();
    n_checks++;
    if (low_cnt !== 256) $display("FAIL reset_init_cycles: got %0d expected 256", low_cnt);
    else n_pass++;
    n_checks++;
    if (bus.din_ready !== 1'b1) $display("FAIL reset_ready_after_init: got %b expected 1", bus.din_ready);
    else n_pass++;
    n_checks++;
    if (bad_out !== 1'b0 || bus.dout !== 16'sd0 || bus.dout_ch !== 1'b0)
      $display("FAIL reset_outputs: bad=%b dout=%0d dout_ch=%0d expected 0/0/0", bad_out, bus.dout, bus.dout_ch);
    else n_pass++;
  endtask

  task automatic test_impulse();
    bit w, er, ro;
    int lat, y, ch, t0, e, ec;
    t0 = 0;
    for (int m = 1; m <= 32; m++) begin
      for (int s = 0; s < D; s++) begin
        if (m == 1 && s == 0) t0 = cyc;
        drive_sample(0, (m == 1 && s == 0) ? 16384 : 0, 1'b0, 0, 0, w);
        if (m == 1 && s == 6) begin
          n_checks++;
          if (cyc - t0 !== 7) $display("FAIL impulse_throughput: got %0d cycles expected 7", cyc - t0);
          else n_pass++;
        end
        if (w) begin
          wait_out(1'b0, 1'b0, lat, y, ch, er, ro);
          e = exp_y.pop_front(); ec = exp_ch.pop_front();
          n_checks++;
          if (lat !== LAT || er || !ro)
            $display("FAIL impulse_timing m=%0d: lat=%0d early=%b ready=%b expected %0d/0/1", m, lat, er, ro, LAT);
          else n_pass++;
          n_checks++;
          if (y !== e || y !== 8 * (8 * m - 1) || ch !== ec)
            $display("FAIL impulse_value m=%0d: got %0d ch %0d expected %0d ch %0d", m, y, ch, 8 * (8 * m - 1), ec);
          else n_pass++;
          if (m == 1) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.dout_valid !== 1'b0 || bus.dout !== 16'sd56)
              $display("FAIL impulse_strobe_hold: valid=%b dout=%0d expected 0/56", bus.dout_valid, bus.dout);
            else n_pass++;
          end
        end
      end
    end
  endtask

  task automatic test_isolation();
    bit w, er, ro;
    int lat, y, ch, e, ec;
    do_reset();
    for (int m = 1; m <= 16; m++) begin
      for (int s = 0; s < D; s++) begin
        for (int c = 0; c < CH; c++) begin
          drive_sample(c, (c == 0 && m == 1 && s == 0) ? 16384 : 0, 1'b0, 0, 0, w);
          if (w) begin
            wait_out(1'b0, 1'b0, lat, y, ch, er, ro);
            e = exp_y.pop_front(); ec = exp_ch.pop_front();
            n_checks++;
            if (lat !== LAT || y !== e || ch !== ec || y !== ((c == 0) ? 8 * (8 * m - 1) : 0))
              $display("FAIL isolation m=%0d ch=%0d: got %0d on ch %0d lat %0d expected %0d on ch %0d lat %0d",
                       m, c, y, ch, lat, e, ec, LAT);
            else n_pass++;
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    bit w, er, ro;
    int lat, y, ch, e, ec, last;
    for (int k = 0; k < TAPS; k++) load_coef(k, 32767);
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      last = 0;
      for (int n = 0; n < 32 * D; n++) begin
        drive_sample(0, (pass == 0) ? 32767 : -32768, 1'b0, 0, 0, w);
        if (w) begin
          wait_out(1'b0, 1'b0, lat, y, ch, er, ro);
          e = exp_y.pop_front(); ec = exp_ch.pop_front();
          last = y;
          n_checks++;
          if (lat !== LAT || y !== e || ch !== ec)
            $display("FAIL saturation_frame pass=%0d n=%0d: got %0d lat %0d expected %0d lat %0d", pass, n, y, lat, e, LAT);
          else n_pass++;
        end
      end
      n_checks++;
      if (last !== ((pass == 0) ? 32767 : -32768))
        $display("FAIL saturation_steady pass=%0d: got %0d expected %0d", pass, last, (pass == 0) ? 32767 : -32768);
      else n_pass++;
    end
  endtask

  task automatic test_write_busy();
    bit w, er, ro;
    int lat, y, ch, e, ec;
    for (int k = 0; k < TAPS; k++) load_coef(k, 16 * k);
    load_coef(0, 1000);
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < D; s++) begin
        drive_sample(1, 256, (f == 1 && s == D - 1), 3, 5000, w);
        if (w) begin
          wait_out(f < 2, f == 2, lat, y, ch, er, ro);
          e = exp_y.pop_front(); ec = exp_ch.pop_front();
          n_checks++;
          if (lat !== LAT || y !== e || ch !== ec)
            $display("FAIL write_busy f=%0d: got %0d ch %0d lat %0d expected %0d ch %0d lat %0d", f, y, ch, lat, e, ec, LAT);
          else n_pass++;
        end
      end
    end
    load_coef(0, 0);
    load_coef(3, 48);
  endtask

  task automatic test_reset_mid_mac();
    bit w, er, ro;
    int lat, y, ch, e, ec, low_cnt, pulses;
    bit nz;
    for (int s = 0; s < D; s++) drive_sample(0, 1000 + s, 1'b0, 0, 0, w);
    exp_y.delete(); exp_ch.delete();
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    low_cnt = 0; pulses = 0; nz = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.din_ready) low_cnt++;
      if (bus.dout_valid) pulses++;
      if (bus.dout != 0) nz = 1'b1;
      @(posedge clk); #1;
    end
    model_clear();
    n_checks++;
    if (pulses !== 0 || nz) $display("FAIL midmac_abort: pulses=%0d dout_nonzero=%b expected 0/0", pulses, nz);
    else n_pass++;
    n_checks++;
    if (low_cnt !== 256) $display("FAIL midmac_init_cycles: got %0d expected 256", low_cnt);
    else n_pass++;
    for (int m = 1; m <= 4; m++) begin
      for (int s = 0; s < D; s++) begin
        drive_sample(0, (m == 1 && s == 0) ? 16384 : 0, 1'b0, 0, 0, w);
        if (w) begin
          wait_out(1'b0, 1'b0, lat, y, ch, er, ro);
          e = exp_y.pop_front(); ec = exp_ch.pop_front();
          n_checks++;
          if (lat !== LAT || y !== e || y !== 8 * (8 * m - 1) || ch !== ec)
            $display("FAIL midmac_rerun m=%0d: got %0d lat %0d expected %0d lat %0d", m, y, lat, 8 * (8 * m - 1), LAT);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_random();
    bit w, er, ro;
    int lat, y, ch, e, ec, outs;
    for (int k = 0; k < TAPS; k++) load_coef(k, int'($urandom_range(0, 4095)) - 2048);
    do_reset();
    outs = 0;
    for (int n = 0; n < 400 && outs < 6; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      drive_sample(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 65535)) - 32768, 1'b0, 0, 0, w);
      if (w) begin
        wait_out(1'b0, 1'b1, lat, y, ch, er, ro);
        e = exp_y.pop_front(); ec = exp_ch.pop_front();
        outs++;
        n_checks++;
        if (lat !== LAT || er || !ro || y !== e || ch !== ec)
          $display("FAIL random out=%0d: got %0d ch %0d lat %0d early=%b expected %0d ch %0d lat %0d",
                   outs, y, ch, lat, er, e, ec, LAT);
        else n_pass++;
      end
    end
    n_checks++;
    if (outs !== 6 || tmo_any) $display("FAIL random_progress: outputs=%0d timeout=%b expected 6/0", outs, tmo_any);
    else n_pass++;
  endtask

  initial begin
    bus.din_valid = 1'b0; bus.din = '0; bus.din_ch = '0;
    bus.c_we = 1'b0; bus.c_addr = '0; bus.c_in = '0;
    model_clear();
    test_reset();
    test_impulse();
    test_isolation();
    test_saturation();
    test_write_busy();
    test_reset_mid_mac();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/fir_decimator_mc.md
# fir_decimator_mc

Multi-channel, time-multiplexed FIR low-pass decimator. It is the successor to the single-channel polyphase decimator. One MAC engine and one shared coefficient set serve CH independent channels. Samples arrive on a valid/ready handshake, so no sample-rate clocks are needed. The block sits between the sample front end and the rate-reduced processing chain, and emits one filtered output per D accepted input samples of each channel.

## Interface
- ORD, 255: filter order; the filter has ORD+1 taps.
- D, 8: decimation factor, 2..ORD+1.
- CH, 2: channel count, 1..8.
- COEFF_SIZE, 16: signed coefficient width.
- SAMPLE_SIZE, 16: signed sample width (input and output).
- ACC_SIZE, 40: accumulator width, at least SAMPLE_SIZE+COEFF_SIZE+clog2(ORD+1).
- OUT_SHIFT, 15: right shift applied to the accumulator before output.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- din_valid  in  1  input sample valid.
- din_ready  out  1  block can accept a sample.
- din  in  SAMPLE_SIZE  signed input sample.
- din_ch  in  max(1,clog2(CH))  channel of din.
- dout_valid  out  1  one-cycle output strobe.
- dout  out  SAMPLE_SIZE  signed filtered output.
- dout_ch  out  max(1,clog2(CH))  channel of dout.
- c_we  in  1  coefficient write enable.
- c_addr  in  clog2(ORD+1)  coefficient index k.
- c_in  in  COEFF_SIZE  coefficient value.

## Operation
- Per-channel ring buffer of ORD+1 samples, per-channel write pointer, per-channel phase counter 0..D-1. Single shared coefficient RAM.
- States and transitions:
  - INIT: entered on rst. Zeroes every sample-buffer entry (one address per cycle, all channels in parallel) over ORD+1 cycles, then goes to IDLE.
  - IDLE: din_ready=1.
  - MAC: computes the full convolution.
  - OUT: presents the result, then returns to IDLE.
- Accept: a sample is taken when din_valid && din_ready. It is written at the channel's write pointer, then the pointer and phase advance (both wrap).
  - Phase wraps from D-1 to 0: IDLE→MAC for that channel.
  - Otherwise: the block stays in IDLE.
  - din_ch >= CH: the sample is accepted and discarded, with no state change.
- MAC computes acc = Σ_{k=0..ORD} c[k]·x[n−k], where x[n] is the sample just written and x[n−k] is the ring entry k places back.
  - Products are full-precision signed.
  - The accumulator is ACC_SIZE bits, two's-complement wrap.
- Output stage:
  - y = (acc + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT.
  - y is saturated to [−2^(SAMPLE_SIZE−1), 2^(SAMPLE_SIZE−1)−1].
- Coefficient writes:
  - Honoured in INIT and IDLE: c[c_addr] ← c_in on the clock edge.
  - Silently ignored in MAC and OUT.
  - Coefficients are not cleared by rst.
- Channel states are fully independent. An output on one channel never alters another channel's buffer or phase.

## Timing
- Reset values:
  - din_ready=0, dout_valid=0, dout=0, dout_ch=0.
  - All phases and pointers are 0.
  - State is INIT.
- rst deasserted at edge R: din_ready rises after edge R+ORD+1.
- Non-wrapping accepts sustain one sample per cycle.
- Let E0 be the edge accepting a phase-wrapping sample.
  - din_ready is 0 from after E0 through the cycle before dout_valid.
  - dout_valid, dout and dout_ch update at edge E0+ORD+3. dout_valid is high for exactly one cycle.
  - din_ready returns to 1 in that same cycle.
  - Internal RAM/MAC pipelining is free, provided this total latency is met.
- dout and dout_ch hold their value until the next output.
- din_valid while din_ready=0: no effect. The upstream stage must hold the sample.
- rst in any state:
  - Aborts MAC/OUT; no dout_valid is issued for the aborted frame.
  - dout returns to 0 and INIT reruns.
  - Coefficients are retained.
- c_we on the same edge as the accept that causes a phase wrap: the write is honoured, since the block is in IDLE at that edge.

## Test plan
- Reset/init: rst high 2 cycles, then low → din_ready=0 for exactly 256 cycles, then 1. dout=0 and dout_valid=0 throughout.
- Impulse (defaults): load c[k]=16·k during INIT. Feed ch0 din=0x4000, then 0x0000 on every subsequent sample → the m-th ch0 output (m=1..32) is 8·(8m−1): 56, 120, …, 2040. Each output appears 258 cycles after the wrapping accept.
- Channel isolation: interleave ch0 (impulse as above) and ch1 (all 0x0000) → ch1 outputs are all 0 with dout_ch=1. ch0 values are unchanged from the previous test.
- Saturation: all c=0x7FFF.
  - Constant din=0x7FFF on ch0 → steady-state dout=0x7FFF.
  - Constant din=0x8000 → dout=0x8000.
- Write while busy: issue c_we with c_addr=0 and c_in=0 during MAC → subsequent outputs still use the original c[0].
- Reset mid-MAC: assert rst 100 cycles into MAC → no dout_valid for that frame, dout=0, INIT reruns. A new impulse run reproduces the impulse-test values without reloading coefficients.
